hazard_tracker: RTL and testbench

//  Sequential hazard/forwarding unit directly downstream of the D-stage decoder in the 5-stage MIPS pipe.

---
 rtl/hazard_tracker.sv | 121 ++++++++++++
 tb/tb_hazard_tracker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Stall/forward unit for the 5-stage MIPS pipe with an E/M/W scoreboard and Tnew countdown.
// Optional stall counter port stall_cnt when HAZARD_STATS_EN is defined.
module hazard_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] waD,
  input  logic       regWriteD,
  input  logic [1:0] Tuse_rsD,
  input  logic [1:0] Tuse_rtD,
  input  logic [1:0] TnewD,
  output logic       stallD,
  output logic [1:0] fwdRsD,
  output logic [1:0] fwdRtD,
  output logic [1:0] fwdRsE,
  output logic [1:0] fwdRtE,
  output logic       fwdRtM
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic [4:0] e_rs_p0, e_rt_p0, e_wa_p0;
  logic [1:0] e_tnew_p0;
  logic [4:0] m_rt_p1, m_wa_p1;
  logic [1:0] m_tnew_p1;
  logic [4:0] w_wa_p2;

  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  // Stall when the youngest pending producer of a source is later than its use
  function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input logic [4:0] ewa, input logic [1:0] etn,
                                     input logic [4:0] mwa, input logic [1:0] mtn);
    return (r != 5'd0) && (((ewa == r) && (etn > tuse)) || ((mwa == r) && (mtn > tuse)));
  endfunction

  function automatic logic [1:0] fwd_d(input logic [4:0] r,
                                       input logic [4:0] ewa, input logic [1:0] etn,
                                       input logic [4:0] mwa, input logic [1:0] mtn,
                                       input logic [4:0] wwa);
    logic [1:0] sel;
    sel = 2'd0;
    if (r != 5'd0) begin
      if (ewa == r)      sel = (etn == 2'd0) ? 2'd1 : 2'd0;
      else if (mwa == r) sel = (mtn == 2'd0) ? 2'd2 : 2'd0;
      else if (wwa == r) sel = 2'd3;
    end
    return sel;
  endfunction

  // M holds a younger value than W, so an unready M match suppresses W
  function automatic logic [1:0] fwd_e(input logic [4:0] r,
                                       input logic [4:0] mwa, input logic [1:0] mtn,
                                       input logic [4:0] wwa);
    logic [1:0] sel;
    sel = 2'd0;
    if (r != 5'd0) begin
      if (mwa == r)      sel = (mtn == 2'd0) ? 2'd2 : 2'd0;
      else if (wwa == r) sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    stallD = src_stall(rsD, Tuse_rsD, e_wa_p0, e_tnew_p0, m_wa_p1, m_tnew_p1) ||
             src_stall(rtD, Tuse_rtD, e_wa_p0, e_tnew_p0, m_wa_p1, m_tnew_p1);
    fwdRsD = fwd_d(rsD, e_wa_p0, e_tnew_p0, m_wa_p1, m_tnew_p1, w_wa_p2);
    fwdRtD = fwd_d(rtD, e_wa_p0, e_tnew_p0, m_wa_p1, m_tnew_p1, w_wa_p2);
    fwdRsE = fwd_e(e_rs_p0, m_wa_p1, m_tnew_p1, w_wa_p2);
    fwdRtE = fwd_e(e_rt_p0, m_wa_p1, m_tnew_p1, w_wa_p2);
    fwdRtM = (m_rt_p1 != 5'd0) && (m_rt_p1 == w_wa_p2);
  end

  // D -> E capture; a stall injects an empty record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rs_p0   <= 5'd0;
      e_rt_p0   <= 5'd0;
      e_wa_p0   <= 5'd0;
      e_tnew_p0 <= 2'd0;
    end else if (stallD) begin
      e_rs_p0   <= 5'd0;
      e_rt_p0   <= 5'd0;
      e_wa_p0   <= 5'd0;
      e_tnew_p0 <= 2'd0;
    end else begin
      e_rs_p0   <= rsD;
      e_rt_p0   <= rtD;
      e_wa_p0   <= regWriteD ? waD : 5'd0;
      e_tnew_p0 <= sat_dec(TnewD);
    end
  end

  // E -> M -> W advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rt_p1   <= 5'd0;
      m_wa_p1   <= 5'd0;
      m_tnew_p1 <= 2'd0;
      w_wa_p2   <= 5'd0;
    end else begin
      m_rt_p1   <= e_rt_p0;
      m_wa_p1   <= e_wa_p0;
      m_tnew_p1 <= sat_dec(e_tnew_p0);
      w_wa_p2   <= m_wa_p1;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stall_cnt <= 32'd0;
    else if (stallD) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: load-use, branch, ALU forwarding, $0, store data, reset mid-stall.
// Define HAZARD_STATS_EN to also exercise the stall counter.
module tb_hazard_tracker;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rsD, rtD, waD;
  logic       regWriteD;
  logic [1:0] Tuse_rsD, Tuse_rtD, TnewD;
  logic       stallD;
  logic [1:0] fwdRsD, fwdRtD, fwdRsE, fwdRtE;
  logic       fwdRtM;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hazard_tracker dut (
    .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .waD(waD), .regWriteD(regWriteD),
    .Tuse_rsD(Tuse_rsD), .Tuse_rtD(Tuse_rtD), .TnewD(TnewD), .stallD(stallD),
    .fwdRsD(fwdRsD), .fwdRtD(fwdRtD), .fwdRsE(fwdRsE), .fwdRtE(fwdRtE), .fwdRtM(fwdRtM)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                       input logic rw, input logic [1:0] tus, input logic [1:0] tut,
                       input logic [1:0] tn);
    rsD = rs; rtD = rt; waD = wa; regWriteD = rw;
    Tuse_rsD = tus; Tuse_rtD = tut; TnewD = tn;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd3, 2'd3, 2'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    nop();
    repeat (4) next_cycle();
  endtask

  task automatic do_reset();
    nop();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0d want=0", stallD); end
    n_checks++; if ({fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM} !== 9'd0) begin n_fail++;
      $display("FAIL reset_fwd got=%b want=0", {fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM}); end
    next_cycle();
  endtask

  // lw $1 followed by a dependent add
  task automatic test_load_use();
    drive(5'd0, 5'd0, 5'd1, 1'b1, 2'd1, 2'd3, 2'd3);
    @(negedge clk);
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL lu_lw_nostall got=%0d want=0", stallD); end
    next_cycle();
    drive(5'd1, 5'd0, 5'd7, 1'b1, 2'd1, 2'd3, 2'd2);
    @(negedge clk);
    n_checks++; if (stallD !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%0d want=1", stallD); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL lu_release got=%0d want=0", stallD); end
    n_checks++; if (fwdRsD !== 2'd0) begin n_fail++; $display("FAIL lu_fwdRsD got=%0d want=0", fwdRsD); end
    next_cycle();
    nop();
    @(negedge clk);
    n_checks++; if (fwdRsE !== 2'd3) begin n_fail++; $display("FAIL lu_fwdRsE got=%0d want=3", fwdRsE); end
    drain();
  endtask

  // add $2 followed by beq on $2
  task automatic test_branch();
    drive(5'd0, 5'd0, 5'd2, 1'b1, 2'd1, 2'd1, 2'd2);
    next_cycle();
    drive(5'd2, 5'd0, 5'd0, 1'b0, 2'd0, 2'd3, 2'd0);
    @(negedge clk);
    n_checks++; if (stallD !== 1'b1) begin n_fail++; $display("FAIL br_stall got=%0d want=1", stallD); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL br_release got=%0d want=0", stallD); end
    n_checks++; if (fwdRsD !== 2'd2) begin n_fail++; $display("FAIL br_fwdRsD got=%0d want=2", fwdRsD); end
    drain();
  endtask

  // add $3 then add $4,$3,$3, then a branch on $3 when it is in W
  task automatic test_alu_fwd();
    drive(5'd0, 5'd0, 5'd3, 1'b1, 2'd1, 2'd1, 2'd2);
    next_cycle();
    drive(5'd3, 5'd3, 5'd4, 1'b1, 2'd1, 2'd1, 2'd2);
    @(negedge clk);
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL alu_nostall got=%0d want=0", stallD); end
    next_cycle();
    nop();
    @(negedge clk);
    n_checks++; if (fwdRsE !== 2'd2) begin n_fail++; $display("FAIL alu_fwdRsE got=%0d want=2", fwdRsE); end
    n_checks++; if (fwdRtE !== 2'd2) begin n_fail++; $display("FAIL alu_fwdRtE got=%0d want=2", fwdRtE); end
    next_cycle();
    drive(5'd3, 5'd0, 5'd0, 1'b0, 2'd0, 2'd3, 2'd0);
    @(negedge clk);
    n_checks++; if (fwdRsD !== 2'd3) begin n_fail++; $display("FAIL alu_fwdRsD_W got=%0d want=3", fwdRsD); end
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL alu_W_nostall got=%0d want=0", stallD); end
    drain();
  endtask

  // ori $0 then beq $0; lw $5 then unused-Tuse read and sw of $5
  task automatic test_zero_and_store();
    drive(5'd0, 5'd0, 5'd0, 1'b1, 2'd1, 2'd3, 2'd2);
    next_cycle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL zero_stall got=%0d want=0", stallD); end
    n_checks++; if ({fwdRsD, fwdRtD} !== 4'd0) begin n_fail++; $display("FAIL zero_fwd got=%b want=0", {fwdRsD, fwdRtD}); end
    next_cycle();
    drive(5'd0, 5'd0, 5'd5, 1'b1, 2'd1, 2'd3, 2'd3);
    next_cycle();
    drive(5'd5, 5'd0, 5'd0, 1'b0, 2'd3, 2'd3, 2'd0);
    @(negedge clk);
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL tuse3_nostall got=%0d want=0", stallD); end
    drive(5'd29, 5'd5, 5'd0, 1'b0, 2'd1, 2'd2, 2'd0);
    #1;
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL sw_nostall got=%0d want=0", stallD); end
    next_cycle();
    nop();
    @(negedge clk);
    n_checks++; if (fwdRtM !== 1'b0) begin n_fail++; $display("FAIL sw_fwdRtM_early got=%0d want=0", fwdRtM); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (fwdRtM !== 1'b1) begin n_fail++; $display("FAIL sw_fwdRtM got=%0d want=1", fwdRtM); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(5'd0, 5'd0, 5'd1, 1'b1, 2'd1, 2'd3, 2'd3);
    next_cycle();
    drive(5'd1, 5'd0, 5'd7, 1'b1, 2'd1, 2'd3, 2'd2);
    @(negedge clk);
    n_checks++; if (stallD !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall got=%0d want=1", stallD); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL rst_async_stall got=%0d want=0", stallD); end
    n_checks++; if ({fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM} !== 9'd0) begin n_fail++;
      $display("FAIL rst_async_fwd got=%b want=0", {fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM}); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (stallD !== 1'b0) begin n_fail++; $display("FAIL rst_empty_sb got=%0d want=0", stallD); end
    drain();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset();
    test_load_use();
    test_branch();
    @(negedge clk);
    n_checks++; if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL cnt_two got=%0d want=2", stall_cnt); end
    next_cycle();
    drive(5'd0, 5'd0, 5'd1, 1'b1, 2'd1, 2'd3, 2'd3);
    next_cycle();
    drive(5'd1, 5'd0, 5'd7, 1'b1, 2'd1, 2'd3, 2'd2);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt;
    next_cycle();
    @(negedge clk);
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap got=%h want=0", stall_cnt); end
    drain();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    nop();
    test_reset();
    test_load_use();
    test_branch();
    test_alu_fwd();
    test_zero_and_store();
    test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
